// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port among N_REQ masters.
// The winner's request is latched, held until mem_ready or the watchdog expires, then returned as a one-cycle pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no transaction; arbitrate among req_valid
// S_BUSY | latched request on mem_*; wait for mem_ready or timeout
// S_RESP | one-cycle req_ready/req_err pulse back to the winner
module mem_bus_arbiter #(
   parameter int          N_REQ          = 2,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
   localparam int         GW             = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*32-1:0]  req_addr,
   input  logic [N_REQ*32-1:0]  req_wdata,
   input  logic [N_REQ*4-1:0]   req_wstrb,
   output logic [N_REQ-1:0]     req_ready,
   output logic [31:0]          req_rdata,
   output logic                 req_err,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   output logic [3:0]           mem_wstrb,
   input  logic [31:0]          mem_rdata,
   output logic [GW-1:0]        grant_id
);

   localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [GW-1:0]    last_grant;
   logic [GW-1:0]    winner;
   logic [GW-1:0]    cand;
   logic             found;
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit;

   // Search starts just after the previous winner so every master gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = GW'((int'(last_grant) + k) % N_REQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (found) state_nxt = S_BUSY;
         S_BUSY:  if (mem_ready || timeout_hit) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mem_valid = (state == S_BUSY);
      req_ready = '0;
      if (state == S_RESP) req_ready[grant_id] = 1'b1;
   end

   // mem_ready wins over the watchdog when both land on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         grant_id   <= '0;
         last_grant <= GW'(N_REQ - 1);
         cnt        <= '0;
         req_rdata  <= '0;
         req_err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  mem_addr   <= req_addr[32*winner +: 32];
                  mem_wdata  <= req_wdata[32*winner +: 32];
                  mem_wstrb  <= req_wstrb[4*winner +: 4];
                  grant_id   <= winner;
                  last_grant <= winner;
                  cnt        <= '0;
               end
            end
            S_BUSY: begin
               if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
               if (mem_ready) begin
                  req_rdata <= mem_rdata;
                  req_err   <= 1'b0;
               end else if (timeout_hit) begin
                  req_rdata <= ERR_RDATA;
                  req_err   <= 1'b1;
               end
            end
            S_RESP: begin
               req_rdata <= '0;
               req_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
